// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and the HI/LO sequencer state encoding.
package mips_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;

  localparam logic [5:0] FUNC_MFHI  = 6'h10;
  localparam logic [5:0] FUNC_MTHI  = 6'h11;
  localparam logic [5:0] FUNC_MFLO  = 6'h12;
  localparam logic [5:0] FUNC_MTLO  = 6'h13;
  localparam logic [5:0] FUNC_MULT  = 6'h18;
  localparam logic [5:0] FUNC_MULTU = 6'h19;
  localparam logic [5:0] FUNC_DIV   = 6'h1A;
  localparam logic [5:0] FUNC_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration on {acc, operand}: right-shifting shift-add
// multiply, or left-shifting restoring divide.
module muldiv_step #(
  parameter int DATA_W = 32
) (
  input  logic              div_i,
  input  logic [DATA_W-1:0] acc_i,
  input  logic [DATA_W-1:0] opnd_i,
  input  logic [DATA_W-1:0] src_i,
  output logic [DATA_W-1:0] acc_o,
  output logic [DATA_W-1:0] opnd_o
);

  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   shifted;
  logic [DATA_W-1:0] diff;
  logic              fits;

  // A magnitude compare (not the subtract borrow) keeps a zero divisor
  // yielding all-ones quotient with the dividend shifted into the remainder.
  always_comb begin
    sum     = {1'b0, acc_i} + (opnd_i[0] ? {1'b0, src_i} : {(DATA_W+1){1'b0}});
    shifted = {acc_i, opnd_i[DATA_W-1]};
    diff    = shifted[DATA_W-1:0] - src_i;
    fits    = (shifted >= {1'b0, src_i});
    if (div_i) begin
      acc_o  = fits ? diff : shifted[DATA_W-1:0];
      opnd_o = {opnd_i[DATA_W-2:0], fits};
    end else begin
      acc_o  = sum[DATA_W:1];
      opnd_o = {sum[0], opnd_i[DATA_W-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// HI/LO unit beside the EX-stage ALU: sequences multi-cycle MULT/DIV,
// handles MFHI/MFLO/MTHI/MTLO and stalls the pipe while an operation runs.
module muldiv_sequencer
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OP_W   = 6,
  parameter int FUNC_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid,
  input  logic [OP_W-1:0]   op,
  input  logic [FUNC_W-1:0] func,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  input  logic              flush,
  output logic              stall,
  output logic              busy,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic [DATA_W-1:0] mf_data
);

  localparam int CNT_W = $clog2(DATA_W);

  muldiv_state_t     state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] opnd_q, opnd_d;
  logic [DATA_W-1:0] src_q, src_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic              negRes_q, negRes_d;
  logic              negRem_q, negRem_d;
  logic              divZero_q, divZero_d;

  logic              slotLive, isMul, isDiv, isSigned, isMthi, isMtlo, hiloOp;
  logic              rsNeg, rtNeg;
  logic [DATA_W-1:0] rsMag, rtMag;
  logic [DATA_W-1:0] stepAcc, stepOpnd;
  logic [DATA_W-1:0] quot, rem;
  logic [2*DATA_W-1:0] prod;

  always_comb begin
    slotLive = valid && (op == OP_W'(OP_SPECIAL)) && !flush;
    isMul    = slotLive && (func == FUNC_W'(FUNC_MULT) || func == FUNC_W'(FUNC_MULTU));
    isDiv    = slotLive && (func == FUNC_W'(FUNC_DIV)  || func == FUNC_W'(FUNC_DIVU));
    isMthi   = slotLive && (func == FUNC_W'(FUNC_MTHI));
    isMtlo   = slotLive && (func == FUNC_W'(FUNC_MTLO));
    hiloOp   = isMul || isDiv || isMthi || isMtlo ||
               (slotLive && (func == FUNC_W'(FUNC_MFHI) || func == FUNC_W'(FUNC_MFLO)));
    isSigned = (func == FUNC_W'(FUNC_MULT)) || (func == FUNC_W'(FUNC_DIV));
    rsNeg    = isSigned && rs_val[DATA_W-1];
    rtNeg    = isSigned && rt_val[DATA_W-1];
    rsMag    = rsNeg ? -rs_val : rs_val;
    rtMag    = rtNeg ? -rt_val : rt_val;
  end

  muldiv_step #(.DATA_W(DATA_W)) u_step (
    .div_i  (state_q == DIV),
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .src_i  (src_q),
    .acc_o  (stepAcc),
    .opnd_o (stepOpnd)
  );

  // Sign fix-up of the final iteration's result; a zero divisor keeps the
  // raw all-ones quotient, and the signed remainder then equals rs_val.
  always_comb begin
    prod = {stepAcc, stepOpnd};
    if (negRes_q) prod = -prod;
    quot = divZero_q ? {DATA_W{1'b1}} : (negRes_q ? -stepOpnd : stepOpnd);
    rem  = negRem_q ? -stepAcc : stepAcc;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (isMul)      state_d = MUL;
          else if (isDiv) state_d = DIV;
        end
        MUL, DIV: if (count_q == '0) state_d = IDLE;
        default:  state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    count_d   = count_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    src_d     = src_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    negRes_d  = negRes_q;
    negRem_d  = negRem_q;
    divZero_d = divZero_q;
    if (flush) begin
      count_d = '0;
    end else if (state_q == IDLE) begin
      if (isMul || isDiv) begin
        acc_d     = '0;
        opnd_d    = rsMag;
        src_d     = rtMag;
        negRes_d  = rsNeg ^ rtNeg;
        negRem_d  = rsNeg;
        divZero_d = isDiv && (rt_val == '0);
        count_d   = CNT_W'(DATA_W - 1);
      end else if (isMthi) begin
        hi_d = rs_val;
      end else if (isMtlo) begin
        lo_d = rs_val;
      end
    end else begin
      acc_d   = stepAcc;
      opnd_d  = stepOpnd;
      count_d = count_q - CNT_W'(1);
      if (count_q == '0) begin
        count_d = '0;
        if (state_q == MUL) begin
          hi_d = prod[2*DATA_W-1:DATA_W];
          lo_d = prod[DATA_W-1:0];
        end else begin
          hi_d = rem;
          lo_d = quot;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q   <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      src_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      negRes_q  <= 1'b0;
      negRem_q  <= 1'b0;
      divZero_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      src_q     <= src_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      negRes_q  <= negRes_d;
      negRem_q  <= negRem_d;
      divZero_q <= divZero_d;
    end
  end

  always_comb begin
    busy    = (state_q != IDLE);
    stall   = busy && hiloOp;
    hi      = hi_q;
    lo      = lo_q;
    mf_data = (func == FUNC_W'(FUNC_MFHI)) ? hi_q : lo_q;
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer with hand-computed results.
module tb_muldiv_sequencer;
  import mips_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic [5:0]  op;
  logic [5:0]  func;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        flush;
  logic        stall;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mf_data;

  int assertCount = 0;
  int failCount   = 0;
  int n;

  muldiv_sequencer #(.DATA_W(32), .OP_W(6), .FUNC_W(6)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   (valid),
    .op      (op),
    .func    (func),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .flush   (flush),
    .stall   (stall),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo),
    .mf_data (mf_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(input logic v, input logic [5:0] f,
                               input logic [31:0] rs, input logic [31:0] rt,
                               input logic fl);
    valid  = v;
    op     = OP_SPECIAL;
    func   = f;
    rs_val = rs;
    rt_val = rt;
    flush  = fl;
  endtask

  task automatic idleInputs();
    applyStimulus(1'b0, 6'h00, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic waitIdle(output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 40) begin
      cycles++;
      tick();
    end
  endtask

  task automatic runOp(input logic [5:0] f, input logic [31:0] rs,
                       input logic [31:0] rt, output int cycles);
    applyStimulus(1'b1, f, rs, rt, 1'b0);
    tick();
    idleInputs();
    waitIdle(cycles);
  endtask

  initial begin
    rst_n = 1'b0;
    idleInputs();
    tick();
    tick();
    checkOutput("reset_busy", {31'h0, busy}, 32'h0);
    checkOutput("reset_hi", hi, 32'h0);
    checkOutput("reset_lo", lo, 32'h0);
    rst_n = 1'b1;
    tick();

    // MULT -3*7 with MFLO right behind it
    applyStimulus(1'b1, FUNC_MULT, 32'hFFFF_FFFD, 32'h7, 1'b0);
    #1;
    checkOutput("mult_start_stall", {31'h0, stall}, 32'h0);
    tick();
    checkOutput("mult_busy", {31'h0, busy}, 32'h1);
    applyStimulus(1'b1, FUNC_MFLO, 32'h0, 32'h0, 1'b0);
    #1;
    n = 0;
    while (stall === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    checkOutput("mflo_stall_cycles", 32'(n), 32'd32);
    checkOutput("mult_mflo", mf_data, 32'hFFFF_FFEB);
    checkOutput("mult_hi", hi, 32'hFFFF_FFFF);
    checkOutput("mult_busy_done", {31'h0, busy}, 32'h0);
    tick();
    idleInputs();

    runOp(FUNC_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
    checkOutput("multu_cycles", 32'(n), 32'd32);
    checkOutput("multu_hi", hi, 32'hFFFF_FFFE);
    checkOutput("multu_lo", lo, 32'h0000_0001);

    runOp(FUNC_DIV, 32'hFFFF_FFF9, 32'h2, n);
    checkOutput("div_lo", lo, 32'hFFFF_FFFD);
    checkOutput("div_hi", hi, 32'hFFFF_FFFF);

    runOp(FUNC_DIVU, 32'd100, 32'h0, n);
    checkOutput("divu0_cycles", 32'(n), 32'd32);
    checkOutput("divu0_lo", lo, 32'hFFFF_FFFF);
    checkOutput("divu0_hi", hi, 32'd100);

    runOp(FUNC_DIV, 32'hFFFF_FFF9, 32'h0, n);
    checkOutput("div0_neg_lo", lo, 32'hFFFF_FFFF);
    checkOutput("div0_neg_hi", hi, 32'hFFFF_FFF9);

    runOp(FUNC_DIV, 32'h8000_0000, 32'hFFFF_FFFF, n);
    checkOutput("div_ovf_lo", lo, 32'h8000_0000);
    checkOutput("div_ovf_hi", hi, 32'h0);

    // Back-to-back: second multiply waits for the first to retire
    applyStimulus(1'b1, FUNC_MULT, 32'd3, 32'd4, 1'b0);
    tick();
    applyStimulus(1'b1, FUNC_MULTU, 32'd2, 32'd5, 1'b0);
    #1;
    n = 0;
    while (stall === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    checkOutput("b2b_stall_cycles", 32'(n), 32'd32);
    checkOutput("b2b_first_lo", lo, 32'd12);
    checkOutput("b2b_first_hi", hi, 32'd0);
    tick();
    checkOutput("b2b_second_busy", {31'h0, busy}, 32'h1);
    idleInputs();
    waitIdle(n);
    checkOutput("b2b_second_lo", lo, 32'd10);

    applyStimulus(1'b1, FUNC_MTHI, 32'h1234, 32'h0, 1'b0);
    #1;
    checkOutput("mthi_stall", {31'h0, stall}, 32'h0);
    tick();
    applyStimulus(1'b1, FUNC_MFHI, 32'h0, 32'h0, 1'b0);
    #1;
    checkOutput("mfhi_data", mf_data, 32'h1234);
    checkOutput("mfhi_stall", {31'h0, stall}, 32'h0);
    applyStimulus(1'b1, FUNC_MTLO, 32'h5678, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b1, FUNC_MFLO, 32'h0, 32'h0, 1'b0);
    #1;
    checkOutput("mflo_data", mf_data, 32'h5678);

    // Flush at cycle 10 of a multiply
    applyStimulus(1'b1, FUNC_MULT, 32'd5, 32'd6, 1'b0);
    tick();
    idleInputs();
    repeat (9) tick();
    applyStimulus(1'b1, FUNC_MFLO, 32'h0, 32'h0, 1'b1);
    #1;
    checkOutput("flush_cycle_stall", {31'h0, stall}, 32'h0);
    tick();
    checkOutput("flush_busy", {31'h0, busy}, 32'h0);
    checkOutput("flush_hi", hi, 32'h1234);
    checkOutput("flush_lo", lo, 32'h5678);

    applyStimulus(1'b1, FUNC_MULT, 32'd5, 32'd6, 1'b1);
    tick();
    checkOutput("flush_start_busy", {31'h0, busy}, 32'h0);
    idleInputs();
    repeat (34) tick();
    checkOutput("flush_start_hi", hi, 32'h1234);
    checkOutput("flush_start_lo", lo, 32'h5678);

    // Reset in the middle of a divide
    applyStimulus(1'b1, FUNC_DIVU, 32'd100, 32'd7, 1'b0);
    tick();
    idleInputs();
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    checkOutput("rst_mid_busy", {31'h0, busy}, 32'h0);
    checkOutput("rst_mid_hi", hi, 32'h0);
    checkOutput("rst_mid_lo", lo, 32'h0);
    rst_n = 1'b1;
    applyStimulus(1'b1, FUNC_MFLO, 32'h0, 32'h0, 1'b0);
    #1;
    checkOutput("rst_mflo_stall", {31'h0, stall}, 32'h0);
    tick();
    idleInputs();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle HI/LO unit for the pipelined MIPS core, sitting beside the EX-stage ALU. It accepts MULT/MULTU/DIV/DIVU and MFHI/MFLO/MTHI/MTLO from the decoded instruction fields and runs a 32-iteration shift-add multiply or restoring divide. It owns the HI/LO registers and raises a pipeline stall when a HI/LO-class instruction arrives while an operation is in flight.

## Interface
- `DATA_W`, 32, operand/HI/LO width; iteration count equals `DATA_W`.
- `OP_W`, 6, opcode field width.
- `FUNC_W`, 6, function field width.

- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `valid` in 1: EX-stage instruction is live this cycle.
- `op` in OP_W: decoded opcode; only `6'h00` (SPECIAL) is considered.
- `func` in FUNC_W: decoded function field.
- `rs_val` in DATA_W: forwarded rs operand (dividend / multiplicand / MT source).
- `rt_val` in DATA_W: forwarded rt operand (divisor / multiplier).
- `flush` in 1: kill the EX instruction and abort any operation in progress.
- `stall` out 1: hold IF/ID/EX this cycle (combinational).
- `busy` out 1: iteration in progress (registered).
- `hi`, `lo` out DATA_W: architectural HI/LO.
- `mf_data` out DATA_W: `hi` for MFHI, otherwise `lo` (combinational).

## Operation
- Decode, only when `valid && op==0 && !flush`: MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13, MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B. Other func values: ignored.
- `hilo_op` = any of the eight above; `stall = busy && valid && op==0 && hilo_op && !flush`.
- States: IDLE, MUL, DIV.
  - IDLE + MULT/MULTU -> MUL; IDLE + DIV/DIVU -> DIV; operands latched, count loaded with DATA_W-1.
  - MUL/DIV: one iteration per cycle, count decrements; at count==0 the edge writes HI/LO and returns to IDLE.
  - Any state + `flush`: return to IDLE, HI/LO unchanged, count cleared.
- MTHI/MTLO in IDLE: write `rs_val` to HI/LO at the edge. In MUL/DIV they stall.
- Signed ops: operands converted to magnitude on accept; sign applied when HI/LO are written. Product sign = XOR of operand signs; quotient sign = XOR; remainder sign = dividend sign.
- Multiply: 64-bit product, HI = upper, LO = lower.
- Divide: LO = quotient, HI = remainder.
  - Divisor 0: LO = all ones, HI = `rs_val`, no sign correction, full 32 cycles.
  - DIV 0x80000000 / -1: LO = 0x80000000, HI = 0.
- Reset: state IDLE, `busy`=0, `hi`=`lo`=0, count 0.

## Timing
- Start accepted at edge E0; `busy`=1 from E0 to E32; HI/LO updated at edge E32; `busy`=0 after E32.
- A HI/LO-class instruction presented after E0 stalls through cycle E31..E32 and proceeds in the cycle after E32. MFHI/MFLO then reads the new value the same cycle.
- A second MULT/DIV issued back-to-back stalls 32 cycles, then starts at the edge following E32.
- `flush` with a start in the same cycle: start is not accepted.
- `flush` while busy: IDLE at the next edge; `stall` is 0 in the flush cycle.
- `rst_n` low mid-operation overrides everything; `busy` and HI/LO are 0 at the next edge.

## Structure
- `mips_pkg`: `OP_SPECIAL`, the eight FUNC_* codes, `muldiv_state_t` enum (IDLE/MUL/DIV).
- Sub-module `muldiv_step`: combinational single iteration (shift-add or restore-subtract) on {acc, operand}, instantiated once. The sequencer holds the state, count, sign flags and HI/LO.

## Test plan
- MULT rs=-3 (0xFFFFFFFD), rt=7; MFLO next cycle -> stall 32 cycles, then `mf_data`=0xFFFFFFEB, HI=0xFFFFFFFF.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001 at E32.
- DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/0 -> LO=0xFFFFFFFF, HI=100.
- MTHI 0x1234 then MFHI in IDLE -> no stall, `mf_data`=0x1234 the cycle after the write.
- MULT, then `flush` at cycle 10 -> `busy` 0 next cycle, HI/LO keep prior values. MULT with `flush` in the same cycle -> never starts.
- `rst_n` low during DIV at cycle 5 -> `busy`=0, HI=LO=0, subsequent MFLO does not stall.
